// File: rtl/touch_sample_scheduler.sv
// -----------------------------------------------------------------------------
// touch_sample_scheduler
//
// Purpose:
//   Schedules X/Y conversions on a resistive touch ADC. A raw pen interrupt
//   is synchronised and debounced. The block then requests a batch of
//   2^AVG_LOG2 conversions and averages them into one coordinate report.
//   It waits SAMPLE_INTERVAL cycles (measured from the report) before it
//   either starts the next batch or declares a pen release.
//
// Ports:
//   CLK           in   system clock
//   RST_n         in   asynchronous active-low reset
//   ADC_PENIRQ_n  in   raw pen interrupt, active low, asynchronous to CLK
//   CONV_REQ      out  one-cycle request for one X/Y conversion
//   CONV_DONE     in   one-cycle pulse, X_IN/Y_IN valid
//   X_IN, Y_IN    in   12-bit raw conversion results
//   X_OUT, Y_OUT  out  12-bit averaged coordinates
//   COORD_VALID   out  X_OUT/Y_OUT hold an unacknowledged report
//   COORD_ACK     in   consumer acknowledge for COORD_VALID
//   TOUCH_ACTIVE  out  pen accepted (debounce passed, not yet released)
//   RELEASE       out  one-cycle pulse on pen-up
//   OVERRUN       out  one-cycle pulse when an unacknowledged report is lost
//   TIMEOUT_ERR   out  sticky: a conversion never completed
//   ERR_CLR       in   synchronous clear of TIMEOUT_ERR
// -----------------------------------------------------------------------------
module touch_sample_scheduler #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SAMPLE_INTERVAL = 500000,
    parameter int CONV_TIMEOUT    = 100000,
    parameter int AVG_LOG2        = 2
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        ADC_PENIRQ_n,
    output logic        CONV_REQ,
    input  logic        CONV_DONE,
    input  logic [11:0] X_IN,
    input  logic [11:0] Y_IN,
    output logic [11:0] X_OUT,
    output logic [11:0] Y_OUT,
    output logic        COORD_VALID,
    input  logic        COORD_ACK,
    output logic        TOUCH_ACTIVE,
    output logic        RELEASE,
    output logic        OVERRUN,
    output logic        TIMEOUT_ERR,
    input  logic        ERR_CLR
);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter serves debounce, conversion timeout and interval,
    // so it is sized for the largest of the three.
    localparam int CNT_MAX = max_int(max_int(DEBOUNCE_CYCLES, SAMPLE_INTERVAL), CONV_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ACC_W   = 12 + AVG_LOG2;
    localparam int SAMP_W  = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(CONV_TIMEOUT - 1);
    // The REPORT cycle is the first cycle of the interval, so INTERVAL itself
    // lasts SAMPLE_INTERVAL-1 cycles (counter values 0 .. SAMPLE_INTERVAL-2).
    localparam logic [CNT_W-1:0]  INT_LAST  = CNT_W'(SAMPLE_INTERVAL - 2);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE  = 3'd1;
    localparam logic [2:0] ST_REQUEST   = 3'd2;
    localparam logic [2:0] ST_WAIT_CONV = 3'd3;
    localparam logic [2:0] ST_REPORT    = 3'd4;
    localparam logic [2:0] ST_INTERVAL  = 3'd5;

    logic              r_pen_meta;
    logic              r_pen_sync;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc_x;
    logic [ACC_W-1:0]  r_acc_y;
    logic [SAMP_W-1:0] r_samp;
    logic              r_conv_req;
    logic              r_touch_active;
    logic              r_release;
    logic [11:0]       r_x_out;
    logic [11:0]       r_y_out;
    logic              r_coord_valid;
    logic              r_overrun;
    logic              r_timeout_err;

    logic              w_pen_down;
    logic [ACC_W-1:0]  w_sum_x;
    logic [ACC_W-1:0]  w_sum_y;
    logic              w_report;
    logic              w_timeout;

    assign w_pen_down = ~r_pen_sync;

    // The running sums include the sample that arrives this cycle. The output
    // registers are therefore loaded on the edge that enters REPORT, and the
    // averaged result is visible during the REPORT cycle itself.
    assign w_sum_x  = r_acc_x + ACC_W'(X_IN);
    assign w_sum_y  = r_acc_y + ACC_W'(Y_IN);
    assign w_report = (r_state == ST_WAIT_CONV) && CONV_DONE && (r_samp == SAMP_LAST);
    assign w_timeout = (r_state == ST_WAIT_CONV) && !CONV_DONE && (r_cnt == TO_LAST);

    assign CONV_REQ     = r_conv_req;
    assign X_OUT        = r_x_out;
    assign Y_OUT        = r_y_out;
    assign COORD_VALID  = r_coord_valid;
    assign TOUCH_ACTIVE = r_touch_active;
    assign RELEASE      = r_release;
    assign OVERRUN      = r_overrun;
    assign TIMEOUT_ERR  = r_timeout_err;

    // Two-flop synchroniser for the asynchronous pen interrupt (idles high).
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_pen_meta <= 1'b1;
            r_pen_sync <= 1'b1;
        end else begin
            r_pen_meta <= ADC_PENIRQ_n;
            r_pen_sync <= r_pen_meta;
        end
    end

    // Main sequencer: debounce, conversion requests, accumulation, interval.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_acc_x        <= {ACC_W{1'b0}};
            r_acc_y        <= {ACC_W{1'b0}};
            r_samp         <= {SAMP_W{1'b0}};
            r_conv_req     <= 1'b0;
            r_touch_active <= 1'b0;
            r_release      <= 1'b0;
        end else begin
            r_conv_req <= 1'b0;
            r_release  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pen_down) begin
                        r_state <= ST_DEBOUNCE;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_pen_down) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state        <= ST_REQUEST;
                        r_conv_req     <= 1'b1;
                        r_touch_active <= 1'b1;
                        r_acc_x        <= {ACC_W{1'b0}};
                        r_acc_y        <= {ACC_W{1'b0}};
                        r_samp         <= {SAMP_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_REQUEST: begin
                    r_state <= ST_WAIT_CONV;
                    r_cnt   <= {CNT_W{1'b0}};
                end
                ST_WAIT_CONV: begin
                    // The ADC pulls PENIRQ itself while converting, so pen
                    // state is deliberately not looked at here.
                    if (CONV_DONE) begin
                        r_acc_x <= w_sum_x;
                        r_acc_y <= w_sum_y;
                        r_samp  <= r_samp + SAMP_W'(1);
                        if (r_samp == SAMP_LAST) begin
                            r_state <= ST_REPORT;
                        end else begin
                            r_state    <= ST_REQUEST;
                            r_conv_req <= 1'b1;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        // Abandon the batch silently: no RELEASE on a fault.
                        r_state        <= ST_IDLE;
                        r_touch_active <= 1'b0;
                        r_acc_x        <= {ACC_W{1'b0}};
                        r_acc_y        <= {ACC_W{1'b0}};
                        r_samp         <= {SAMP_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_INTERVAL;
                    r_cnt   <= {CNT_W{1'b0}};
                end
                ST_INTERVAL: begin
                    if (r_cnt == INT_LAST) begin
                        if (w_pen_down) begin
                            // Pen still down: resample without re-debouncing.
                            r_state    <= ST_REQUEST;
                            r_conv_req <= 1'b1;
                            r_acc_x    <= {ACC_W{1'b0}};
                            r_acc_y    <= {ACC_W{1'b0}};
                            r_samp     <= {SAMP_W{1'b0}};
                        end else begin
                            r_state        <= ST_IDLE;
                            r_touch_active <= 1'b0;
                            r_release      <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_touch_active <= 1'b0;
                end
            endcase
        end
    end

    // Coordinate output registers and the valid/ack handshake. A new report
    // wins over a simultaneous ACK, and only a report that replaces an
    // unacknowledged one counts as an overrun.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_x_out       <= 12'd0;
            r_y_out       <= 12'd0;
            r_coord_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_report) begin
            r_x_out       <= 12'(w_sum_x >> AVG_LOG2);
            r_y_out       <= 12'(w_sum_y >> AVG_LOG2);
            r_coord_valid <= 1'b1;
            r_overrun     <= r_coord_valid && !COORD_ACK;
        end else begin
            r_overrun <= 1'b0;
            if (r_coord_valid && COORD_ACK) begin
                r_coord_valid <= 1'b0;
            end
        end
    end

    // Sticky conversion-timeout flag; setting takes priority over ERR_CLR.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (ERR_CLR) begin
            r_timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_touch_sample_scheduler.sv
module tb_touch_sample_scheduler;

    localparam int DEB = 4;
    localparam int SI  = 20;
    localparam int TO  = 50;
    localparam int AL  = 2;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        ADC_PENIRQ_n;
    logic        CONV_REQ;
    logic        CONV_DONE;
    logic [11:0] X_IN;
    logic [11:0] Y_IN;
    logic [11:0] X_OUT;
    logic [11:0] Y_OUT;
    logic        COORD_VALID;
    logic        COORD_ACK;
    logic        TOUCH_ACTIVE;
    logic        RELEASE;
    logic        OVERRUN;
    logic        TIMEOUT_ERR;
    logic        ERR_CLR;

    int vectors = 0;
    int errors  = 0;

    touch_sample_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .SAMPLE_INTERVAL(SI),
        .CONV_TIMEOUT   (TO),
        .AVG_LOG2       (AL)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .ADC_PENIRQ_n(ADC_PENIRQ_n),
        .CONV_REQ    (CONV_REQ),
        .CONV_DONE   (CONV_DONE),
        .X_IN        (X_IN),
        .Y_IN        (Y_IN),
        .X_OUT       (X_OUT),
        .Y_OUT       (Y_OUT),
        .COORD_VALID (COORD_VALID),
        .COORD_ACK   (COORD_ACK),
        .TOUCH_ACTIVE(TOUCH_ACTIVE),
        .RELEASE     (RELEASE),
        .OVERRUN     (OVERRUN),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ERR_CLR     (ERR_CLR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bounded wait for a conversion request; an expired bound is a miscompare.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (CONV_REQ !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        vectors++;
        if (CONV_REQ !== 1'b1) begin
            errors++;
            $display("FAIL %s: CONV_REQ=%b after %0d cycles, required 1", tag, CONV_REQ, n);
        end
    endtask

    // Answer one request: wait for CONV_REQ, then CONV_DONE one cycle later.
    task automatic answer(input logic [11:0] x, input logic [11:0] y, input logic ack_with_done);
        wait_req("conv_req");
        tick();
        CONV_DONE = 1'b1;
        X_IN      = x;
        Y_IN      = y;
        COORD_ACK = ack_with_done;
        tick();
        CONV_DONE = 1'b0;
        COORD_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST_n        = 1'b0;
        ADC_PENIRQ_n = 1'b1;
        CONV_DONE    = 1'b0;
        X_IN         = 12'd0;
        Y_IN         = 12'd0;
        COORD_ACK    = 1'b0;
        ERR_CLR      = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({CONV_REQ, COORD_VALID, TOUCH_ACTIVE, RELEASE, OVERRUN, TIMEOUT_ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {CONV_REQ, COORD_VALID, TOUCH_ACTIVE, RELEASE, OVERRUN, TIMEOUT_ERR});
        end
        vectors++;
        if ({X_OUT, Y_OUT} !== 24'd0) begin
            errors++;
            $display("FAIL reset_coords: X_OUT=%0d Y_OUT=%0d, required 0 0", X_OUT, Y_OUT);
        end
        RST_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_short_pen();
        logic seen;
        seen = 1'b0;
        ADC_PENIRQ_n = 1'b0;
        tick();
        tick();
        ADC_PENIRQ_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (CONV_REQ === 1'b1 || TOUCH_ACTIVE === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL short_pen: CONV_REQ/TOUCH_ACTIVE seen=%b, required 0", seen);
        end
    endtask

    task automatic test_report();
        int n;
        ADC_PENIRQ_n = 1'b0;
        n = 0;
        while (CONV_REQ !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 7) begin
            errors++;
            $display("FAIL debounce_latency: %0d cycles, required 7", n);
        end
        vectors++;
        if (TOUCH_ACTIVE !== 1'b1) begin
            errors++;
            $display("FAIL touch_active: got %b, required 1", TOUCH_ACTIVE);
        end
        // CONV_DONE during the REQUEST cycle carries junk and must be ignored.
        CONV_DONE = 1'b1;
        X_IN      = 12'd4000;
        Y_IN      = 12'd0;
        tick();
        vectors++;
        if (CONV_REQ !== 1'b0) begin
            errors++;
            $display("FAIL conv_req_width: CONV_REQ=%b in second cycle, required 0", CONV_REQ);
        end
        X_IN = 12'd100;
        Y_IN = 12'd4095;
        tick();
        CONV_DONE = 1'b0;
        answer(12'd101, 12'd4095, 1'b0);
        answer(12'd102, 12'd4095, 1'b0);
        answer(12'd103, 12'd4095, 1'b0);
        vectors++;
        if (COORD_VALID !== 1'b1 || X_OUT !== 12'd101 || Y_OUT !== 12'd4095 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL report1: VALID=%b X=%0d Y=%0d OVR=%b, required 1 101 4095 0",
                     COORD_VALID, X_OUT, Y_OUT, OVERRUN);
        end
    endtask

    task automatic test_overrun_release();
        int  n;
        logic seen;
        n = 0;
        while (CONV_REQ !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != SI) begin
            errors++;
            $display("FAIL interval: %0d cycles report to CONV_REQ, required %0d", n, SI);
        end
        answer(12'd200, 12'd0, 1'b0);
        answer(12'd204, 12'd1, 1'b0);
        answer(12'd208, 12'd2, 1'b0);
        answer(12'd212, 12'd3, 1'b0);
        vectors++;
        if (OVERRUN !== 1'b1 || COORD_VALID !== 1'b1 || X_OUT !== 12'd206 || Y_OUT !== 12'd1) begin
            errors++;
            $display("FAIL overrun_report: OVR=%b VALID=%b X=%0d Y=%0d, required 1 1 206 1",
                     OVERRUN, COORD_VALID, X_OUT, Y_OUT);
        end
        tick();
        vectors++;
        if (OVERRUN !== 1'b0 || COORD_VALID !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: OVR=%b VALID=%b, required 0 1", OVERRUN, COORD_VALID);
        end
        COORD_ACK = 1'b1;
        tick();
        COORD_ACK = 1'b0;
        vectors++;
        if (COORD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: VALID=%b, required 0", COORD_VALID);
        end
        ADC_PENIRQ_n = 1'b1;
        n = 0;
        while (RELEASE !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != SI - 2 || TOUCH_ACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL release: after %0d cycles TOUCH_ACTIVE=%b, required %0d and 0",
                     n, TOUCH_ACTIVE, SI - 2);
        end
        tick();
        vectors++;
        if (RELEASE !== 1'b0) begin
            errors++;
            $display("FAIL release_pulse: RELEASE=%b, required 0", RELEASE);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (CONV_REQ === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: CONV_REQ seen=%b, required 0", seen);
        end
    endtask

    task automatic test_ack_priority();
        int n;
        ADC_PENIRQ_n = 1'b0;
        for (int i = 0; i < 4; i++) answer(12'd1000, 12'd2000, 1'b0);
        vectors++;
        if (COORD_VALID !== 1'b1 || X_OUT !== 12'd1000 || Y_OUT !== 12'd2000) begin
            errors++;
            $display("FAIL prio_report1: VALID=%b X=%0d Y=%0d, required 1 1000 2000",
                     COORD_VALID, X_OUT, Y_OUT);
        end
        answer(12'd7, 12'd0, 1'b0);
        answer(12'd7, 12'd0, 1'b0);
        answer(12'd7, 12'd0, 1'b0);
        answer(12'd8, 12'd0, 1'b1);
        vectors++;
        if (COORD_VALID !== 1'b1 || OVERRUN !== 1'b0 || X_OUT !== 12'd7 || Y_OUT !== 12'd0) begin
            errors++;
            $display("FAIL prio_report2: VALID=%b OVR=%b X=%0d Y=%0d, required 1 0 7 0",
                     COORD_VALID, OVERRUN, X_OUT, Y_OUT);
        end
        tick();
        vectors++;
        if (COORD_VALID !== 1'b1) begin
            errors++;
            $display("FAIL prio_hold: VALID=%b, required 1", COORD_VALID);
        end
        COORD_ACK = 1'b1;
        tick();
        COORD_ACK = 1'b0;
        ADC_PENIRQ_n = 1'b1;
        n = 0;
        while (RELEASE !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (RELEASE !== 1'b1 || COORD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL prio_release: RELEASE=%b VALID=%b, required 1 0", RELEASE, COORD_VALID);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic seen;
        ADC_PENIRQ_n = 1'b0;
        wait_req("timeout_req");
        repeat (TO - 1) tick();
        vectors++;
        if (TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: TIMEOUT_ERR=%b, required 0", TIMEOUT_ERR);
        end
        ERR_CLR = 1'b1;
        tick();
        vectors++;
        if (TIMEOUT_ERR !== 1'b0 || TOUCH_ACTIVE !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge: ERR=%b TOUCH=%b, required 0 1", TIMEOUT_ERR, TOUCH_ACTIVE);
        end
        tick();
        vectors++;
        if (TIMEOUT_ERR !== 1'b1 || TOUCH_ACTIVE !== 1'b0 || RELEASE !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set: ERR=%b TOUCH=%b REL=%b, required 1 0 0",
                     TIMEOUT_ERR, TOUCH_ACTIVE, RELEASE);
        end
        ERR_CLR      = 1'b0;
        ADC_PENIRQ_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (CONV_REQ === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0 || TIMEOUT_ERR !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: req_seen=%b ERR=%b, required 0 1", seen, TIMEOUT_ERR);
        end
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        vectors++;
        if (TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: ERR=%b, required 0", TIMEOUT_ERR);
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        ADC_PENIRQ_n = 1'b0;
        answer(12'd500, 12'd500, 1'b0);
        answer(12'd500, 12'd500, 1'b0);
        wait_req("third_req");
        tick();
        RST_n = 1'b0;
        #1;
        vectors++;
        if ({CONV_REQ, COORD_VALID, TOUCH_ACTIVE, RELEASE, OVERRUN, TIMEOUT_ERR} !== 6'b0
            || X_OUT !== 12'd0 || Y_OUT !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b X=%0d Y=%0d, required 000000 0 0",
                     {CONV_REQ, COORD_VALID, TOUCH_ACTIVE, RELEASE, OVERRUN, TIMEOUT_ERR}, X_OUT, Y_OUT);
        end
        CONV_DONE = 1'b1;
        X_IN      = 12'd4095;
        Y_IN      = 12'd4095;
        tick();
        RST_n = 1'b1;
        seen  = 1'b0;
        tick();
        tick();
        CONV_DONE = 1'b0;
        n = 2;
        while (CONV_REQ !== 1'b1 && n < 40) begin
            if (COORD_VALID === 1'b1) seen = 1'b1;
            tick();
            n++;
        end
        vectors++;
        if (n != 7 || seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_redebounce: %0d cycles valid_seen=%b, required 7 0", n, seen);
        end
        answer(12'd8, 12'd10, 1'b0);
        answer(12'd8, 12'd20, 1'b0);
        answer(12'd8, 12'd30, 1'b0);
        answer(12'd8, 12'd40, 1'b0);
        vectors++;
        if (COORD_VALID !== 1'b1 || X_OUT !== 12'd8 || Y_OUT !== 12'd25) begin
            errors++;
            $display("FAIL reset_fresh_batch: VALID=%b X=%0d Y=%0d, required 1 8 25",
                     COORD_VALID, X_OUT, Y_OUT);
        end
    endtask

    initial begin
        test_reset();
        test_short_pen();
        test_report();
        test_overrun_release();
        test_ack_priority();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/touch_sample_scheduler.md
TOUCH_SAMPLE_SCHEDULER -- requirements
Module: touch_sample_scheduler

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning CLK cycles pen must stay down before the first conversion.
REQ-002 SHALL have parameter SAMPLE_INTERVAL, default 500000, meaning CLK cycles between averaged coordinate reports.
REQ-003 SHALL have parameter CONV_TIMEOUT, default 100000, meaning maximum CLK cycles from CONV_REQ to CONV_DONE.
REQ-004 SHALL have parameter AVG_LOG2, default 2, legal range 0-3, meaning log2 of conversions averaged per report.
REQ-005 SHALL use one clock and an asynchronous active-low reset: CLK input 1 system clock; RST_n input 1 asynchronous active-low reset.
REQ-006 SHALL have ADC_PENIRQ_n  input  1  raw pen interrupt from the touch ADC, active low, asynchronous.
REQ-007 SHALL have CONV_REQ  output  1  one-cycle pulse requesting one X/Y conversion from the ADC control block.
REQ-008 SHALL have CONV_DONE  input  1  one-cycle pulse: X_IN/Y_IN valid.
REQ-009 SHALL have X_IN, Y_IN  input  12 each  raw conversion results.
REQ-010 SHALL have X_OUT, Y_OUT  output  12 each  averaged coordinates.
REQ-011 SHALL have COORD_VALID output 1 and COORD_ACK input 1: valid/ack handshake for X_OUT/Y_OUT.
REQ-012 SHALL have TOUCH_ACTIVE output 1 (pen accepted), RELEASE output 1 (one-cycle pulse on pen-up), OVERRUN output 1 (one-cycle pulse), TIMEOUT_ERR output 1 (sticky).
REQ-013 SHALL have ERR_CLR  input  1  synchronous clear of TIMEOUT_ERR.

Function
REQ-014 SHALL synchronise ADC_PENIRQ_n through two flops; pen_down = synchronised value low; all decisions use pen_down.
REQ-015 SHALL implement states IDLE, DEBOUNCE, REQUEST, WAIT_CONV, REPORT, INTERVAL.
REQ-016 IDLE: pen_down -> DEBOUNCE with counter cleared.
REQ-017 DEBOUNCE: count while pen_down; pen released -> IDLE; count reaches DEBOUNCE_CYCLES-1 -> REQUEST, TOUCH_ACTIVE set, accumulators and sample count cleared.
REQ-018 REQUEST: CONV_REQ high exactly one cycle, then WAIT_CONV; timeout counter cleared.
REQ-019 WAIT_CONV: pen_down ignored (ADC drives PENIRQ during conversion); on CONV_DONE add X_IN/Y_IN to (12+AVG_LOG2)-bit accumulators, increment sample count; count reaching 2^AVG_LOG2 -> REPORT, else -> REQUEST.
REQ-020 WAIT_CONV: CONV_DONE absent for CONV_TIMEOUT cycles -> set TIMEOUT_ERR, discard batch, clear TOUCH_ACTIVE, -> IDLE (no RELEASE pulse).
REQ-021 CONV_DONE outside WAIT_CONV SHALL be ignored.
REQ-022 REPORT (one cycle): X_OUT/Y_OUT <= accumulator >> AVG_LOG2 (truncation), COORD_VALID set, -> INTERVAL.
REQ-023 If COORD_VALID already high and COORD_ACK low in REPORT cycle, SHALL overwrite outputs and pulse OVERRUN one cycle.
REQ-024 COORD_VALID SHALL clear the cycle after COORD_ACK sampled high; ACK with VALID low ignored; REPORT takes priority over simultaneous ACK (VALID stays high, no OVERRUN).
REQ-025 INTERVAL: counts SAMPLE_INTERVAL-1 cycles measured from REPORT; at terminal count: pen_down -> REQUEST (no re-debounce, accumulators cleared); else -> IDLE, TOUCH_ACTIVE cleared, RELEASE pulsed one cycle.
REQ-026 Report latency: REPORT occurs the cycle after the final CONV_DONE.
REQ-027 ERR_CLR clears TIMEOUT_ERR; simultaneous set and clear: set wins.
REQ-028 Report period = SAMPLE_INTERVAL cycles + conversion time of the next batch.

Reset
REQ-029 RST_n low SHALL asynchronously force IDLE, all counters/accumulators 0, synchroniser flops 1, X_OUT/Y_OUT 0, COORD_VALID/CONV_REQ/TOUCH_ACTIVE/RELEASE/OVERRUN/TIMEOUT_ERR 0.
REQ-030 Reset mid-conversion SHALL abandon the batch; no CONV_REQ or COORD_VALID until a new debounce completes.

Verification (bench parameters DEBOUNCE_CYCLES=4, SAMPLE_INTERVAL=20, CONV_TIMEOUT=50, AVG_LOG2=2)
REQ-031 Pen low 2 cycles then high -> no CONV_REQ, TOUCH_ACTIVE stays 0.
REQ-032 Pen held low; answer 4 CONV_REQs with X=100,101,102,103, Y=4095 x4 -> COORD_VALID with X_OUT=101, Y_OUT=4095 one cycle after 4th CONV_DONE.
REQ-033 Pen held, consumer never ACKs -> second report pulses OVERRUN once, X_OUT updated, COORD_VALID remains 1.
REQ-034 Pen released during INTERVAL -> at terminal count RELEASE one-cycle pulse, TOUCH_ACTIVE 0, state IDLE, no further CONV_REQ.
REQ-035 CONV_REQ never answered -> TIMEOUT_ERR=1 after 50 cycles, TOUCH_ACTIVE 0; ERR_CLR pulse -> TIMEOUT_ERR 0.
REQ-036 RST_n asserted between 2nd and 3rd CONV_DONE -> all outputs 0 immediately; later CONV_DONE pulses ignored.
